// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq -- sequencer for CHIP-8 arithmetic/logic opcodes of the form 8XYN.
//
// An accepted instruction walks through the following steps:
//   1. Read VX, then VY, from an external register file. Read data arrives one
//      cycle after the strobe.
//   2. Present VX/VY and N to an external ALU. Hold them stable for
//      ALU_LATENCY cycles, then sample the ALU result, flag and error.
//   3. Write the result back to VX. Then, for flag-producing ops, write the
//      flag to VF.
// Any opcode other than 8XYN completes immediately with err set and makes no
// register-file access. An ALU error aborts the instruction before any
// write-back.
//
// Parameters
//   ALU_LATENCY   cycles from operands stable to ALU outputs valid (1..4)
//
// Configuration macro
//   ALU_SEQ_LOGIC_VF_RESET_EN  when defined, the logic ops (N = 1, 2, 3) also
//                              write VF = 8'h00, as the original COSMAC
//                              interpreter did. When undefined, VF is left
//                              untouched by those ops.
//
// Ports
//   clk, rst_n       clock (rising edge) and asynchronous active-low reset
//   start_i          request to run instr_i; only looked at while idle
//   instr_i[15:0]    CHIP-8 opcode 8XYN
//   busy_o           high whenever the sequencer is not idle
//   done_o, err_o    one-cycle completion pulse and its abort flag
//   rf_addr_o[3:0]   register-file address
//   rf_re_o          read strobe; rf_rdata_i is valid the following cycle
//   rf_rdata_i[7:0]  register-file read data
//   rf_we_o          write strobe
//   rf_wdata_o[7:0]  write data
//   alu_op1_o/op2_o  ALU operands VX / VY
//   alu_opcode_o     ALU function select (N)
//   alu_out_i, alu_carry_i, alu_err_i   ALU result, flag and illegal-op flag
// -----------------------------------------------------------------------------
module alu_seq #(
  parameter int unsigned ALU_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [15:0] instr_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [3:0]  rf_addr_o,
  output logic        rf_re_o,
  input  logic [7:0]  rf_rdata_i,
  output logic        rf_we_o,
  output logic [7:0]  rf_wdata_o,
  output logic [7:0]  alu_op1_o,
  output logic [7:0]  alu_op2_o,
  output logic [3:0]  alu_opcode_o,
  input  logic [7:0]  alu_out_i,
  input  logic        alu_carry_i,
  input  logic        alu_err_i
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD_X  = 3'd1,
    ST_RD_Y  = 3'd2,
    ST_LATCH = 3'd3,
    ST_EXEC  = 3'd4,
    ST_WR_X  = 3'd5,
    ST_WR_F  = 3'd6,
    ST_DONE  = 3'd7
  } state_e;

  // Last value of the EXEC wait counter. The ALU outputs are sampled on the
  // edge that leaves EXEC.
  localparam logic [1:0] LAT_LAST = 2'(ALU_LATENCY - 1);

`ifdef ALU_SEQ_LOGIC_VF_RESET_EN
  localparam logic VF_RESET_EN = 1'b1;
`else
  localparam logic VF_RESET_EN = 1'b0;
`endif

  // N = 1, 2, 3 are the bitwise logic ops (OR, AND, XOR).
  function automatic logic is_logic_op(input logic [3:0] n);
    logic r;
    case (n)
      4'h1, 4'h2, 4'h3: r = 1'b1;
      default:          r = 1'b0;
    endcase
    return r;
  endfunction

  // Ops whose completion includes a VF write after the VX write.
  function automatic logic needs_flag_write(input logic [3:0] n);
    logic r;
    case (n)
      4'h4, 4'h5, 4'h6, 4'h7, 4'hE: r = 1'b1;
      4'h1, 4'h2, 4'h3:             r = VF_RESET_EN;
      default:                      r = 1'b0;
    endcase
    return r;
  endfunction

  state_e      state_q, state_d;
  logic [3:0]  x_q, x_d;
  logic [3:0]  y_q, y_d;
  logic [3:0]  opcode_q, opcode_d;
  logic [7:0]  op1_q, op1_d;
  logic [7:0]  op2_q, op2_d;
  logic [7:0]  res_q, res_d;
  logic        flag_q, flag_d;
  logic        err_flag_q, err_flag_d;
  logic [1:0]  lat_cnt_q, lat_cnt_d;

  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [3:0]  rf_addr_q, rf_addr_d;
  logic        rf_re_q, rf_re_d;
  logic        rf_we_q, rf_we_d;
  logic [7:0]  rf_wdata_q, rf_wdata_d;

  // Next-state logic plus capture of the instruction fields, operands and
  // ALU results.
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    opcode_d   = opcode_q;
    op1_d      = op1_q;
    op2_d      = op2_q;
    res_d      = res_q;
    flag_d     = flag_q;
    err_flag_d = err_flag_q;
    lat_cnt_d  = lat_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          x_d      = instr_i[11:8];
          y_d      = instr_i[7:4];
          opcode_d = instr_i[3:0];
          if (instr_i[15:12] != 4'h8) begin
            err_flag_d = 1'b1;
            state_d    = ST_DONE;
          end else begin
            err_flag_d = 1'b0;
            state_d    = ST_RD_X;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RD_X: begin
        state_d = ST_RD_Y;
      end
      ST_RD_Y: begin
        // VX data, requested in RD_X, is on the bus now.
        op1_d   = rf_rdata_i;
        state_d = ST_LATCH;
      end
      ST_LATCH: begin
        op2_d     = rf_rdata_i;
        lat_cnt_d = 2'd0;
        state_d   = ST_EXEC;
      end
      ST_EXEC: begin
        if (lat_cnt_q == LAT_LAST) begin
          res_d = alu_out_i;
          // With the COSMAC quirk enabled, the logic ops clear VF
          // instead of writing whatever flag the ALU reports.
          if (VF_RESET_EN && is_logic_op(opcode_q)) begin
            flag_d = 1'b0;
          end else begin
            flag_d = alu_carry_i;
          end
          if (alu_err_i) begin
            err_flag_d = 1'b1;
            state_d    = ST_DONE;
          end else begin
            state_d = ST_WR_X;
          end
        end else begin
          lat_cnt_d = lat_cnt_q + 2'd1;
        end
      end
      ST_WR_X: begin
        if (needs_flag_write(opcode_q)) begin
          state_d = ST_WR_F;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_WR_F: begin
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode from the next state, so every output comes straight from
  // a flop and is aligned with the state it belongs to.
  always_comb begin
    busy_d     = (state_d != ST_IDLE);
    done_d     = (state_d == ST_DONE);
    err_d      = 1'b0;
    rf_addr_d  = 4'h0;
    rf_re_d    = 1'b0;
    rf_we_d    = 1'b0;
    rf_wdata_d = 8'h00;

    case (state_d)
      ST_RD_X: begin
        rf_addr_d = x_d;
        rf_re_d   = 1'b1;
      end
      ST_RD_Y: begin
        rf_addr_d = y_d;
        rf_re_d   = 1'b1;
      end
      ST_WR_X: begin
        rf_addr_d  = x_d;
        rf_we_d    = 1'b1;
        rf_wdata_d = res_d;
      end
      ST_WR_F: begin
        rf_addr_d  = 4'hF;
        rf_we_d    = 1'b1;
        rf_wdata_d = {7'b0000000, flag_d};
      end
      ST_DONE: begin
        err_d = err_flag_d;
      end
      default: begin
        rf_addr_d = 4'h0;
      end
    endcase
  end

  // State, captured fields and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      x_q        <= 4'h0;
      y_q        <= 4'h0;
      opcode_q   <= 4'h0;
      op1_q      <= 8'h00;
      op2_q      <= 8'h00;
      res_q      <= 8'h00;
      flag_q     <= 1'b0;
      err_flag_q <= 1'b0;
      lat_cnt_q  <= 2'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rf_addr_q  <= 4'h0;
      rf_re_q    <= 1'b0;
      rf_we_q    <= 1'b0;
      rf_wdata_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      opcode_q   <= opcode_d;
      op1_q      <= op1_d;
      op2_q      <= op2_d;
      res_q      <= res_d;
      flag_q     <= flag_d;
      err_flag_q <= err_flag_d;
      lat_cnt_q  <= lat_cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      rf_addr_q  <= rf_addr_d;
      rf_re_q    <= rf_re_d;
      rf_we_q    <= rf_we_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign rf_addr_o    = rf_addr_q;
  assign rf_re_o      = rf_re_q;
  assign rf_we_o      = rf_we_q;
  assign rf_wdata_o   = rf_wdata_q;
  assign alu_op1_o    = op1_q;
  assign alu_op2_o    = op2_q;
  assign alu_opcode_o = opcode_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed testbench for alu_seq (default ALU_LATENCY = 1). It provides a
// behavioural register file and CHIP-8 ALU around the sequencer. Expected
// register contents, latencies and flags are hand-computed constants.
module tb_alu_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] instr;
  logic        busy, done, err;
  logic [3:0]  rf_addr;
  logic        rf_re, rf_we;
  logic [7:0]  rf_rdata, rf_wdata;
  logic [7:0]  alu_op1, alu_op2;
  logic [3:0]  alu_opcode;
  logic [7:0]  alu_out;
  logic        alu_carry, alu_err;

  int n_checks = 0;
  int n_fail   = 0;
  int overlap  = 0;

  logic [7:0]  vreg [0:15];
  logic        pl_en;
  logic [3:0]  pl_addr;
  logic [7:0]  pl_data;

  alu_seq #(.ALU_LATENCY(1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (start),
    .instr_i      (instr),
    .busy_o       (busy),
    .done_o       (done),
    .err_o        (err),
    .rf_addr_o    (rf_addr),
    .rf_re_o      (rf_re),
    .rf_rdata_i   (rf_rdata),
    .rf_we_o      (rf_we),
    .rf_wdata_o   (rf_wdata),
    .alu_op1_o    (alu_op1),
    .alu_op2_o    (alu_op2),
    .alu_opcode_o (alu_opcode),
    .alu_out_i    (alu_out),
    .alu_carry_i  (alu_carry),
    .alu_err_i    (alu_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file: bench preload port, DUT write port, registered read.
  always @(posedge clk) begin
    if (pl_en) vreg[pl_addr] <= pl_data;
    else if (rf_we) vreg[rf_addr] <= rf_wdata;
    if (rf_re) rf_rdata <= vreg[rf_addr];
  end

  // Reference CHIP-8 8XYN ALU.
  always_comb begin
    alu_out   = 8'h00;
    alu_carry = 1'b0;
    alu_err   = 1'b0;
    case (alu_opcode)
      4'h0: alu_out = alu_op2;
      4'h1: alu_out = alu_op1 | alu_op2;
      4'h2: alu_out = alu_op1 & alu_op2;
      4'h3: alu_out = alu_op1 ^ alu_op2;
      4'h4: {alu_carry, alu_out} = {1'b0, alu_op1} + {1'b0, alu_op2};
      4'h5: begin alu_out = alu_op1 - alu_op2; alu_carry = (alu_op1 >= alu_op2); end
      4'h6: begin alu_out = {1'b0, alu_op1[7:1]}; alu_carry = alu_op1[0]; end
      4'h7: begin alu_out = alu_op2 - alu_op1; alu_carry = (alu_op2 >= alu_op1); end
      4'hE: begin alu_out = {alu_op1[6:0], 1'b0}; alu_carry = alu_op1[7]; end
      default: alu_err = 1'b1;
    endcase
  end

  // Read and write strobes must never overlap.
  always @(negedge clk) begin
    if (rf_re && rf_we) overlap++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic preload(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Issue one instruction and follow it to done. lat counts the clock edges
  // after the edge that samples start (-1 means done never arrived).
  task automatic run_instr(input logic [15:0] ins, output int lat, output logic e,
                           output int n_re, output int n_we);
    int cyc;
    lat = -1; e = 1'bx; n_re = 0; n_we = 0;
    @(negedge clk);
    start = 1'b1; instr = ins;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (cyc < 40) begin
      if (rf_re) n_re++;
      if (rf_we) n_we++;
      if (done) begin
        lat = cyc; e = err;
        break;
      end
      @(posedge clk); #1;
      cyc++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; instr = 16'h0000; pl_en = 1'b0;
    pl_addr = 4'h0; pl_data = 8'h00;
    #3;
    n_checks++; if ({busy, done, err} !== 3'b000) begin n_fail++; $display("FAIL reset_status: busy/done/err=%b required 000", {busy, done, err}); end
    n_checks++; if ({rf_re, rf_we} !== 2'b00) begin n_fail++; $display("FAIL reset_strobes: re/we=%b required 00", {rf_re, rf_we}); end
    n_checks++; if ({rf_addr, rf_wdata} !== 12'h000) begin n_fail++; $display("FAIL reset_rf_bus: %h required 000", {rf_addr, rf_wdata}); end
    n_checks++; if ({alu_op1, alu_op2, alu_opcode} !== 20'h00000) begin n_fail++; $display("FAIL reset_alu_bus: %h required 00000", {alu_op1, alu_op2, alu_opcode}); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: %b required 0", busy); end
  endtask

  task automatic test_add();
    int lat, nre, nwe; logic e;
    preload(4'h1, 8'hFF); preload(4'h2, 8'h01); preload(4'hF, 8'h33);
    run_instr(16'h8124, lat, e, nre, nwe);
    n_checks++; if (lat !== 6) begin n_fail++; $display("FAIL add_latency: %0d required 6", lat); end
    n_checks++; if (e !== 1'b0) begin n_fail++; $display("FAIL add_err: %b required 0", e); end
    n_checks++; if (vreg[1] !== 8'h00) begin n_fail++; $display("FAIL add_v1: %h required 00", vreg[1]); end
    n_checks++; if (vreg[15] !== 8'h01) begin n_fail++; $display("FAIL add_vf: %h required 01", vreg[15]); end
    n_checks++; if (nre !== 2 || nwe !== 2) begin n_fail++; $display("FAIL add_strobes: re=%0d we=%0d required 2/2", nre, nwe); end
  endtask

  task automatic test_sub();
    int lat, nre, nwe; logic e;
    preload(4'h1, 8'h05); preload(4'h2, 8'h07);
    run_instr(16'h8125, lat, e, nre, nwe);
    n_checks++; if (vreg[1] !== 8'hFE) begin n_fail++; $display("FAIL sub_v1: %h required fe", vreg[1]); end
    n_checks++; if (vreg[15] !== 8'h00) begin n_fail++; $display("FAIL sub_vf: %h required 00", vreg[15]); end
    preload(4'h1, 8'h05);
    run_instr(16'h8127, lat, e, nre, nwe);
    n_checks++; if (vreg[1] !== 8'h02) begin n_fail++; $display("FAIL subn_v1: %h required 02", vreg[1]); end
    n_checks++; if (vreg[15] !== 8'h01) begin n_fail++; $display("FAIL subn_vf: %h required 01", vreg[15]); end
    n_checks++; if (lat !== 6) begin n_fail++; $display("FAIL subn_latency: %0d required 6", lat); end
  endtask

  task automatic test_shift_vf();
    int lat, nre, nwe; logic e;
    preload(4'hF, 8'h81);
    run_instr(16'h8F06, lat, e, nre, nwe);
    n_checks++; if (vreg[15] !== 8'h01) begin n_fail++; $display("FAIL shr_vf: %h required 01", vreg[15]); end
    preload(4'hF, 8'h81);
    run_instr(16'h8F0E, lat, e, nre, nwe);
    n_checks++; if (vreg[15] !== 8'h01) begin n_fail++; $display("FAIL shl_vf: %h required 01", vreg[15]); end
  endtask

  task automatic test_logic();
    int lat, nre, nwe; logic e;
    preload(4'h3, 8'hF0); preload(4'h4, 8'h3C); preload(4'hF, 8'hAA);
    run_instr(16'h8342, lat, e, nre, nwe);
    n_checks++; if (vreg[3] !== 8'h30) begin n_fail++; $display("FAIL and_v3: %h required 30", vreg[3]); end
`ifdef ALU_SEQ_LOGIC_VF_RESET_EN
    n_checks++; if (vreg[15] !== 8'h00) begin n_fail++; $display("FAIL and_vf: %h required 00", vreg[15]); end
    n_checks++; if (lat !== 6) begin n_fail++; $display("FAIL and_latency: %0d required 6", lat); end
`else
    n_checks++; if (vreg[15] !== 8'hAA) begin n_fail++; $display("FAIL and_vf: %h required aa", vreg[15]); end
    n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL and_latency: %0d required 5", lat); end
`endif
  endtask

  task automatic test_move_same_reg();
    int lat, nre, nwe; logic e;
    preload(4'h5, 8'h11); preload(4'h6, 8'h22); preload(4'hF, 8'h5A);
    run_instr(16'h8560, lat, e, nre, nwe);
    n_checks++; if (vreg[5] !== 8'h22) begin n_fail++; $display("FAIL mov_v5: %h required 22", vreg[5]); end
    n_checks++; if (vreg[15] !== 8'h5A || nwe !== 1) begin n_fail++; $display("FAIL mov_vf: vf=%h we=%0d required 5a/1", vreg[15], nwe); end
    n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL mov_latency: %0d required 5", lat); end
    preload(4'h3, 8'h10);
    run_instr(16'h8334, lat, e, nre, nwe);
    n_checks++; if (vreg[3] !== 8'h20 || nre !== 2) begin n_fail++; $display("FAIL same_reg: v3=%h re=%0d required 20/2", vreg[3], nre); end
  endtask

  task automatic test_errors();
    int lat, nre, nwe; logic e;
    run_instr(16'h7123, lat, e, nre, nwe);
    // Non-8XYN goes straight to DONE on the start edge, so done is up in the
    // very next cycle.
    n_checks++; if (lat !== 0 || e !== 1'b1) begin n_fail++; $display("FAIL non8_done: lat=%0d err=%b required 0/1", lat, e); end
    n_checks++; if (nre !== 0 || nwe !== 0) begin n_fail++; $display("FAIL non8_rf: re=%0d we=%0d required 0/0", nre, nwe); end
    n_checks++; if (busy !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL after_done: busy=%b err=%b required 0/0", busy, err); end
    preload(4'h1, 8'h33); preload(4'h2, 8'h44);
    run_instr(16'h8128, lat, e, nre, nwe);
    n_checks++; if (lat !== 4 || e !== 1'b1) begin n_fail++; $display("FAIL aluerr_done: lat=%0d err=%b required 4/1", lat, e); end
    n_checks++; if (nwe !== 0 || vreg[1] !== 8'h33) begin n_fail++; $display("FAIL aluerr_nowrite: we=%0d v1=%h required 0/33", nwe, vreg[1]); end
  endtask

  task automatic test_back_to_back_busy();
    int cyc, lat, extra;
    preload(4'h5, 8'h10); preload(4'h6, 8'h20); preload(4'hF, 8'h77);
    @(negedge clk);
    start = 1'b1; instr = 16'h8564;
    @(posedge clk); #1;
    instr = 16'h8651;
    cyc = 0; lat = -1;
    while (cyc < 40) begin
      if (done) begin lat = cyc; break; end
      @(posedge clk); #1;
      cyc++;
      if (cyc == 3) begin start = 1'b0; instr = 16'h7000; end
    end
    extra = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done || busy) extra++;
    end
    n_checks++; if (lat !== 6) begin n_fail++; $display("FAIL busy_latency: %0d required 6", lat); end
    n_checks++; if (extra !== 0) begin n_fail++; $display("FAIL busy_queued: %0d extra busy cycles required 0", extra); end
    n_checks++; if (vreg[5] !== 8'h30 || vreg[6] !== 8'h20 || vreg[15] !== 8'h00) begin n_fail++; $display("FAIL busy_regs: v5=%h v6=%h vf=%h required 30/20/00", vreg[5], vreg[6], vreg[15]); end
  endtask

  task automatic test_reset_midflight();
    int cyc, seen, lat, nre, nwe; logic e;
    preload(4'h1, 8'hFF); preload(4'h2, 8'h01); preload(4'hF, 8'h55);
    @(negedge clk);
    start = 1'b1; instr = 16'h8124;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (!(rf_we && rf_addr == 4'h1) && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    n_checks++; if (cyc >= 20) begin n_fail++; $display("FAIL rst_reach_wrx: cycles=%0d required <20", cyc); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (rf_we !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_immediate: we=%b busy=%b required 0/0", rf_we, busy); end
    seen = 0;
    repeat (3) begin @(posedge clk); #1; if (done || rf_we) seen++; end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin @(posedge clk); #1; if (done || rf_we) seen++; end
    n_checks++; if (seen !== 0) begin n_fail++; $display("FAIL rst_dropped: %0d done/we cycles required 0", seen); end
    n_checks++; if (vreg[1] !== 8'hFF || vreg[15] !== 8'h55) begin n_fail++; $display("FAIL rst_regs: v1=%h vf=%h required ff/55", vreg[1], vreg[15]); end
    run_instr(16'h8124, lat, e, nre, nwe);
    n_checks++; if (lat !== 6 || e !== 1'b0) begin n_fail++; $display("FAIL rst_rerun: lat=%0d err=%b required 6/0", lat, e); end
    n_checks++; if (vreg[1] !== 8'h00 || vreg[15] !== 8'h01) begin n_fail++; $display("FAIL rst_rerun_regs: v1=%h vf=%h required 00/01", vreg[1], vreg[15]); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_shift_vf();
    test_logic();
    test_move_same_reg();
    test_errors();
    test_back_to_back_busy();
    test_reset_midflight();
    n_checks++; if (overlap !== 0) begin n_fail++; $display("FAIL re_we_overlap: %0d cycles required 0", overlap); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
